// File: rtl/prog_loader.sv
// Byte-stream programming sequencer: parses sync/address/payload/checksum records
// and emits one registered instruction-memory write per accepted record.
module prog_loader #(
  parameter int         STATE_COUNT = 8,
  parameter int         INST_BYTES  = 6,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] END_BYTE    = 8'h5A
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           prog_enable,
  input  logic                           byte_valid,
  input  logic [7:0]                     data_in,
  output logic                           wr_en,
  output logic [$clog2(STATE_COUNT)-1:0] wr_addr,
  output logic [8*INST_BYTES-1:0]        wr_data,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [$clog2(STATE_COUNT):0]   frame_count
);

  localparam int AW = $clog2(STATE_COUNT);
  localparam int DW = 8 * INST_BYTES;
  localparam int FW = AW + 1;
  localparam int CW = $clog2(INST_BYTES) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   shift_r;
  logic [7:0]      acc_r;
  logic [CW-1:0]   cnt_r;

  // Running XOR checksum over address and payload bytes.
  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Record parser FSM with registered write port and sticky session status.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {AW{1'b0}};
      shift_r     <= {DW{1'b0}};
      acc_r       <= 8'h00;
      cnt_r       <= {CW{1'b0}};
      wr_en       <= 1'b0;
      wr_addr     <= {AW{1'b0}};
      wr_data     <= {DW{1'b0}};
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
      frame_count <= {FW{1'b0}};
    end else begin
      wr_en <= 1'b0;
      if (!prog_enable) begin
        // Dropping enable abandons any partial record; status is kept for the host.
        state_r <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            state_r     <= SYNC;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            frame_count <= {FW{1'b0}};
          end
          SYNC: begin
            if (byte_valid) begin
              if (data_in == SYNC_BYTE) begin
                state_r <= ADDR;
                acc_r   <= 8'h00;
              end else if (data_in == END_BYTE) begin
                state_r <= DONE;
                done    <= 1'b1;
              end else begin
                state_r  <= ERR;
                error    <= 1'b1;
                err_code <= 2'd1;
              end
            end else begin
              state_r <= SYNC;
            end
          end
          ADDR: begin
            if (byte_valid) begin
              if ({1'b0, data_in} >= 9'(STATE_COUNT)) begin
                state_r  <= ERR;
                error    <= 1'b1;
                err_code <= 2'd2;
              end else begin
                state_r <= DATA;
                addr_r  <= data_in[AW-1:0];
                acc_r   <= chk_next(8'h00, data_in);
                cnt_r   <= {CW{1'b0}};
              end
            end else begin
              state_r <= ADDR;
            end
          end
          DATA: begin
            if (byte_valid) begin
              shift_r <= (shift_r << 8) | DW'(data_in);
              acc_r   <= chk_next(acc_r, data_in);
              cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
              if (cnt_r == CW'(INST_BYTES - 1)) begin
                state_r <= CHK;
              end else begin
                state_r <= DATA;
              end
            end else begin
              state_r <= DATA;
            end
          end
          CHK: begin
            if (byte_valid) begin
              if (data_in == acc_r) begin
                state_r <= SYNC;
                wr_en   <= 1'b1;
                wr_addr <= addr_r;
                wr_data <= shift_r;
                if (frame_count != {FW{1'b1}}) begin
                  frame_count <= frame_count + {{(FW-1){1'b0}}, 1'b1};
                end else begin
                  frame_count <= frame_count;
                end
              end else begin
                state_r  <= ERR;
                error    <= 1'b1;
                err_code <= 2'd3;
              end
            end else begin
              state_r <= CHK;
            end
          end
          DONE:    state_r <= DONE;
          ERR:     state_r <= ERR;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: record-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_prog_loader;

  localparam int SC = 8;
  localparam int IB = 6;
  localparam int AW = 3;
  localparam int DW = 48;
  localparam int FW = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_enable = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [FW-1:0] frame_count;

  prog_loader dut (
    .clock(clock), .rst_n(rst_n), .prog_enable(prog_enable),
    .byte_valid(byte_valid), .data_in(data_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .error(error), .err_code(err_code), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: session phase (0 idle, 1 parsing, 2 finished) plus the bytes of the record so far.
  int            m_phase = 0;
  logic [7:0]    rec[$];
  bit            m_live = 1'b0;
  logic          m_wr_en = 1'b0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  logic          m_done = 1'b0;
  logic          m_error = 1'b0;
  logic [1:0]    m_err_code = 2'd0;
  int            m_frames = 0;

  task automatic m_fail(input logic [1:0] code);
    if (!m_error) m_err_code = code;
    m_error = 1'b1;
    m_phase = 2;
    rec.delete();
  endtask

  always @(posedge clock) begin
    logic [7:0] x;
    logic [DW-1:0] d;
    cyc++;
    if (!rst_n) begin
      m_live = 1'b1; m_phase = 0; rec.delete();
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
      m_done = 1'b0; m_error = 1'b0; m_err_code = 2'd0; m_frames = 0;
    end else begin
      m_wr_en = 1'b0;
      if (!prog_enable) begin
        m_phase = 0; rec.delete();
      end else if (m_phase == 0) begin
        m_phase = 1; rec.delete();
        m_done = 1'b0; m_error = 1'b0; m_err_code = 2'd0; m_frames = 0;
      end else if (m_phase == 1 && byte_valid) begin
        rec.push_back(data_in);
        if (rec.size() == 1) begin
          if (data_in == 8'h5A) begin
            m_done = 1'b1; m_phase = 2; rec.delete();
          end else if (data_in != 8'hA5) begin
            m_fail(2'd1);
          end
        end else if (rec.size() == 2) begin
          if (data_in >= SC) m_fail(2'd2);
        end else if (rec.size() == IB + 3) begin
          x = 8'h00; d = '0;
          for (int i = 1; i <= IB + 1; i++) x ^= rec[i];
          for (int i = 2; i <= IB + 1; i++) d = (d << 8) | DW'(rec[i]);
          if (rec[IB + 2] == x) begin
            m_wr_en = 1'b1; m_wr_addr = rec[1][AW-1:0]; m_wr_data = d;
            if (m_frames < (1 << FW) - 1) m_frames++;
            rec.delete();
          end else begin
            m_fail(2'd3);
          end
        end
      end
    end
  end

  int            wr_cyc[$];
  logic [AW-1:0] wr_adr[$];

  // Cycle-by-cycle comparison of every output against the model, plus a write log.
  always @(negedge clock) begin
    if (m_live) begin
      check("wr_en", 64'(wr_en), 64'(m_wr_en));
      check("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
      check("wr_data", 64'(wr_data), 64'(m_wr_data));
      check("done", 64'(done), 64'(m_done));
      check("error", 64'(error), 64'(m_error));
      check("err_code", 64'(err_code), 64'(m_err_code));
      check("frame_count", 64'(frame_count), 64'(m_frames));
      if (wr_en === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_adr.push_back(wr_addr);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    data_in = b;
    @(negedge clock);
    byte_valid = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic send_rec(input logic [7:0] a, input logic [DW-1:0] d, input bit bad, input int gmax);
    logic [7:0] c;
    c = a;
    send_byte(8'hA5, $urandom_range(0, gmax));
    send_byte(a, $urandom_range(0, gmax));
    for (int i = IB - 1; i >= 0; i--) begin
      c ^= d[8*i +: 8];
      send_byte(d[8*i +: 8], $urandom_range(0, gmax));
    end
    send_byte(bad ? (c ^ 8'h01) : c, $urandom_range(0, gmax));
  endtask

  task automatic new_session();
    prog_enable = 1'b0;
    @(negedge clock);
    prog_enable = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int n;
    int r;
    repeat (2) @(negedge clock);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_frame_count", 64'(frame_count), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;

    // 1: single valid record
    prog_enable = 1'b1;
    @(negedge clock);
    send_rec(8'h03, 48'h112233445566, 1'b0, 0);
    check("s1_wr_en", 64'(wr_en), 64'd1);
    check("s1_wr_addr", 64'(wr_addr), 64'd3);
    check("s1_wr_data", 64'(wr_data), 64'h112233445566);
    check("s1_frame_count", 64'(frame_count), 64'd1);
    check("s1_error", 64'(error), 64'd0);

    // 2: back-to-back records then end marker
    new_session();
    wr_cyc.delete();
    send_rec(8'h01, 48'hA1B2C3D4E5F6, 1'b0, 0);
    send_rec(8'h07, 48'h0102030405FF, 1'b0, 0);
    send_byte(8'h5A, 0);
    @(negedge clock);
    check("s2_pulses", 64'(wr_cyc.size()), 64'd2);
    if (wr_cyc.size() == 2) check("s2_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd9);
    check("s2_frame_count", 64'(frame_count), 64'd2);
    check("s2_done", 64'(done), 64'd1);

    // 3: checksum error, later bytes ignored, session restart clears status
    new_session();
    wr_cyc.delete();
    send_rec(8'h03, 48'h112233445566, 1'b1, 0);
    check("s3_error", 64'(error), 64'd1);
    check("s3_err_code", 64'(err_code), 64'd3);
    send_rec(8'h03, 48'h112233445566, 1'b0, 0);
    check("s3_no_write", 64'(wr_cyc.size()), 64'd0);
    new_session();
    check("s3_error_clr", 64'(error), 64'd0);
    check("s3_code_clr", 64'(err_code), 64'd0);
    check("s3_frames_clr", 64'(frame_count), 64'd0);

    // 4: bad sync and out-of-range address
    send_byte(8'h00, 0);
    check("s4_sync_error", 64'(error), 64'd1);
    check("s4_sync_code", 64'(err_code), 64'd1);
    new_session();
    wr_cyc.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h08, 0);
    check("s4_addr_error", 64'(error), 64'd1);
    check("s4_addr_code", 64'(err_code), 64'd2);
    check("s4_no_write", 64'(wr_cyc.size()), 64'd0);

    // 5: aborted partial record, then a full record for address 5
    new_session();
    wr_adr.delete();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    new_session();
    send_rec(8'h05, 48'hCAFEF00D1234, 1'b0, 0);
    @(negedge clock);
    check("s5_writes", 64'(wr_adr.size()), 64'd1);
    if (wr_adr.size() == 1) check("s5_addr", 64'(wr_adr[0]), 64'd5);

    // 6: random gaps, then reset mid-record
    new_session();
    send_rec(8'h03, 48'h112233445566, 1'b0, 5);
    check("s6_wr_en", 64'(wr_en), 64'd1);
    check("s6_wr_data", 64'(wr_data), 64'h112233445566);
    new_session();
    wr_cyc.delete();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    rst_n = 1'b0;
    @(negedge clock);
    check("s6_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("s6_rst_wr_data", 64'(wr_data), 64'd0);
    check("s6_rst_frames", 64'(frame_count), 64'd0);
    check("s6_rst_status", 64'({done, error, err_code}), 64'd0);
    rst_n = 1'b1;
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h74, 0);
    check("s6_rst_no_write", 64'(wr_cyc.size()), 64'd0);

    // frame_count saturation
    new_session();
    for (int i = 0; i < 17; i++) send_rec(8'(i % SC), {16'(i), 32'($urandom)}, 1'b0, 0);
    check("sat_frame_count", 64'(frame_count), 64'hF);

    // randomized traffic
    new_session();
    n = 0;
    while (n < 80) begin
      n++;
      r = $urandom_range(0, 19);
      if (m_phase != 1 || r == 0) new_session();
      else if (r == 1) send_byte(8'h5A, $urandom_range(0, 2));
      else if (r == 2) send_byte(8'($urandom), 0);
      else if (r == 3) begin
        send_byte(8'hA5, 0);
        send_byte(8'($urandom_range(0, SC - 1)), 0);
        new_session();
      end else begin
        send_rec(8'($urandom_range(0, 9)), {16'($urandom), 32'($urandom)},
                 $urandom_range(0, 5) == 0, 3);
      end
    end
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream programming sequencer that loads the controller's instruction memory while prog_enable is high.
- Parses framed records from data_in: sync, address, instruction-word payload, checksum. Validates each record and issues one write-port pulse per valid record.
- Reports done/error status so the host knows when the FSM program is committed.
- Sits between the chip's byte input pins and the instruction memory write port. The controller holds its state at 0 while programming.

Parameters:
- STATE_COUNT, 8, number of instruction-memory entries; wr_addr width is $clog2(STATE_COUNT).
- INST_BYTES, 6, bytes per instruction word; wr_data width is 8*INST_BYTES.
- SYNC_BYTE, 8'hA5, record start marker.
- END_BYTE, 8'h5A, end-of-program marker.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- prog_enable, input, 1, programming session active.
- byte_valid, input, 1, data_in carries a new byte this cycle.
- data_in, input, 8, stream byte.
- wr_en, output, 1, one-cycle instruction-memory write strobe.
- wr_addr, output, $clog2(STATE_COUNT), write address.
- wr_data, output, 8*INST_BYTES, instruction word; first payload byte is the MSB.
- done, output, 1, sticky: END_BYTE received with no error.
- error, output, 1, sticky: record rejected.
- err_code, output, 2, 0 none, 1 bad sync, 2 address out of range, 3 checksum mismatch.
- frame_count, output, $clog2(STATE_COUNT)+1, records written this session; saturates at all-ones.

Behaviour:
- Reset (rst_n low at an edge):
  - FSM goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, err_code=0, frame_count=0.
  - Reset mid-record discards the partial record with no write.
- FSM states: IDLE, SYNC, ADDR, DATA, CHK, DONE, ERR.
- A byte is consumed only on an edge where byte_valid=1 and the FSM is in SYNC/ADDR/DATA/CHK. Bytes are ignored in IDLE/DONE/ERR.
- IDLE -> SYNC on the first edge with prog_enable=1. That same edge clears done, error, err_code and frame_count.
- Any edge with prog_enable=0 forces IDLE:
  - A partial record is discarded with no write.
  - done/error/err_code/frame_count hold their values.
- SYNC:
  - SYNC_BYTE -> ADDR; checksum accumulator cleared.
  - END_BYTE -> DONE; done=1.
  - Any other byte -> ERR with code 1.
- ADDR:
  - Byte value >= STATE_COUNT (full 8-bit compare) -> ERR with code 2.
  - Otherwise latch the address, acc = byte, payload byte counter = 0, -> DATA.
- DATA:
  - Shift the byte into a payload shift register from the LSB end, so the first byte ends up in the MSB. acc ^= byte.
  - After INST_BYTES bytes -> CHK.
- CHK:
  - byte == acc -> SYNC, and schedule a write.
  - Otherwise -> ERR with code 3; no write.
- Write timing:
  - wr_en, wr_addr and wr_data are registered.
  - wr_en is high for exactly the one cycle after the accepting CHK edge. wr_addr/wr_data are valid in that cycle and hold until the next write.
  - The FSM is already in SYNC during the wr_en cycle, so back-to-back records need no gap bytes.
  - frame_count increments on the CHK-accept edge, saturating.
  - If prog_enable falls on the CHK-accept edge, the record is not written.
- DONE and ERR are terminal until prog_enable drops and is re-asserted.
  - error=1 implies done=0.
  - err_code records the first error only.
- Duplicate addresses are legal; the last write wins. No address-coverage check is made.
- No combinational path from data_in or byte_valid to any output.

Test Plan:
1. Reset, then prog_enable=1 and stream A5 03 11 22 33 44 55 66 74 -> one cycle after the 74 byte: wr_en=1, wr_addr=3, wr_data=48'h112233445566, frame_count=1, error=0.
2. Two valid records back-to-back with byte_valid held high every cycle, then 5A -> two single-cycle wr_en pulses exactly 9 cycles apart, frame_count=2, done=1.
3. Record A5 03 11 22 33 44 55 66 75 -> no wr_en, error=1, err_code=3; later bytes including A5 are ignored. Drop prog_enable for one cycle and re-assert -> error=0, err_code=0, frame_count=0.
4. First byte 00 -> error=1, err_code=1. Separately, A5 08 -> error=1, err_code=2, no write.
5. Drop prog_enable after A5 03 11 22, then re-assert and send a full valid record for address 5 -> only address 5 is written; the aborted record produces no wr_en.
6. Hold byte_valid=0 between every byte with random gaps of 0-5 cycles during a valid record -> same single write as scenario 1. Assert rst_n=0 mid-record -> all outputs return to 0 and no write occurs.
